fxu_reservation_station: RTL
============================

# fxu_reservation_station

Age-ordered reservation station for one fixed-point unit. Sits between the dispatch stage (which drives it with the same instr_valid/rob_idx/operand/owner/opcode/immediate bundle it sends to each FXU and samples its `full`) and the FXU execution pipeline. It:
- holds up to DEPTH dispatched instructions;
- captures missing operands from the common data bus (CDB);
- issues the oldest fully-ready entry through a valid/ready handshake.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_W, 4, ROB index / owner tag width (16-entry ROB)
- DATA_W, 16, operand width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  dispatch request this cycle
- in_rob_idx  in  TAG_W  ROB slot of dispatched instruction
- in_a_valid / in_b_valid  in  1  operand already resolved
- in_a_value / in_b_value  in  DATA_W  operand value (meaningful when *_valid)
- in_a_owner / in_b_owner  in  TAG_W  producing ROB slot (meaningful when !*_valid)
- in_opcode  in  4  FXU opcode
- in_i  in  8  immediate
- full  out  1  count == DEPTH
- count  out  clog2(DEPTH+1)  occupied entries
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  ROB slot producing the result
- cdb_value  in  DATA_W  result value
- flush  in  1  discard all entries (mispredict)
- issue_valid  out  1  an entry is ready and presented
- issue_ready  in  1  FXU accepts this cycle
- issue_rob_idx  out  TAG_W; issue_a, issue_b  out  DATA_W; issue_opcode  out  4; issue_i  out  8

## Operation
Storage is a compacting queue: slots 0..count-1 valid, slot 0 oldest. Each slot holds rob_idx, opcode, imm, and for each of A and B: valid, value, owner.

Per-cycle priority, evaluated on current state:
1. **Reset** (rst_n=0): all slots invalid, count=0. Every output 0.
2. **Flush**: all slots invalid, count=0. Dispatch and issue ignored. issue_valid is forced 0 during the flush cycle.
3. **Wakeup**: for every valid slot and operand with valid=0 and owner==cdb_tag while cdb_valid: set valid=1 and value=cdb_value.
4. **Select**: ready = A.valid & B.valid, using pre-wakeup state. sel = lowest-index ready slot.
   - issue_valid = any ready & !flush.
   - issue_* fields = slot sel fields; all 0 when issue_valid=0.
5. **Issue** (issue_valid & issue_ready): remove sel. Slots above sel shift down one, carrying their wakeup updates.
6. **Dispatch** (in_valid & !full & !flush): write at index count minus (1 if issue fired).
   - CDB bypass: an incoming operand with !in_*_valid, owner==cdb_tag and cdb_valid is written as valid with cdb_value.
7. **Dispatch while full**: in_valid & full is dropped with no state change. The upstream buffer must stall on full.
8. **Count**: next count = count + dispatch − issue. Never exceeds DEPTH or goes below 0.

Further rules:
- Wakeup uses only the tag compare. Both operands of one slot may wake on the same broadcast.
- Opcode and immediate are passed through uninterpreted. Mov-immediate style instructions arrive with both operand valids set.

## Timing
- Dispatch at edge N: visible in count/full from N+1. Issuable from N+1 at earliest, if its operands were valid or bypassed at N.
- Wakeup at edge N: the slot can issue in cycle N+1. There is no same-cycle CDB→issue path.
- issue_* and issue_valid are combinational from registered slot state and flush only. They do not depend on issue_ready, in_*, or cdb_*.
- full and count are combinational from the registered count only.
  - full does not drop in the cycle an issue fires; the freed slot is usable next cycle.
  - No combinational path exists from in_valid or issue_ready to full.
- Holding: while issue_valid=1 and issue_ready=0, the presented entry and its fields stay stable. Exception: an older slot becoming ready moves the selection to that older slot.

## Test plan
- **Reset then idle**: hold rst_n=0 for 2 cycles, then dispatch nothing → count=0, full=0, issue_valid=0, all issue fields 0.
- **Ready dispatch**:
  - Stimulus: with issue_ready=1, dispatch rob 3, a=0x0011, b=0x0022 (both valid), opcode 0, imm 0x05.
  - Response: next cycle issue_valid=1, rob 3, a=0x0011, b=0x0022. The following cycle count=0.
- **Wakeup and bypass**:
  - Stimulus: dispatch rob 5 with A owner 2 invalid. In the same cycle, cdb_valid tag 2 value 0xBEEF.
  - Response: next cycle issue_a=0xBEEF. Repeat with the broadcast one cycle later → issue one cycle later.
- **Oldest-first and compaction**:
  - Stimulus: fill rob 1,2,3,4; only 2 and 4 ready; issue_ready=1.
  - Response: rob 2 issues then rob 4. When CDB wakes 1 and 3, rob 1 issues before rob 3.
- **Full boundary**:
  - Stimulus: with issue_ready=0, fill DEPTH entries → full=1. Dispatch rob 9.
  - Response: dropped, count stays DEPTH. Raise issue_ready for one cycle → full=0 next cycle. Rob 9 accepted only when re-dispatched.
- **Flush mid-operation**:
  - Stimulus: 3 entries held, flush=1 with simultaneous in_valid and issue_ready.
  - Response: issue_valid=0 that cycle; next cycle count=0 and the dispatched instruction is absent.

Source files
------------

// File: rtl/fxu_reservation_station_if.sv
// Bundle between dispatch / CDB / FXU and the FXU reservation station.
//   master : the surrounding pipeline (drives dispatch, CDB, flush, issue_ready)
//   slave  : the reservation station (drives full, count and the issue bundle)
// Ports: dispatch bundle (in_*), occupancy (full, count), CDB (cdb_*), flush,
//        issue handshake (issue_valid/issue_ready) and issued fields (issue_*).
interface fxu_reservation_station_if #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 3
);
    logic              in_valid;
    logic [TAG_W-1:0]  in_rob_idx;
    logic              in_a_valid;
    logic              in_b_valid;
    logic [DATA_W-1:0] in_a_value;
    logic [DATA_W-1:0] in_b_value;
    logic [TAG_W-1:0]  in_a_owner;
    logic [TAG_W-1:0]  in_b_owner;
    logic [3:0]        in_opcode;
    logic [7:0]        in_i;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_rob_idx;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [3:0]        issue_opcode;
    logic [7:0]        issue_i;

    modport master (
        output in_valid, in_rob_idx, in_a_valid, in_b_valid, in_a_value, in_b_value,
               in_a_owner, in_b_owner, in_opcode, in_i, cdb_valid, cdb_tag, cdb_value,
               flush, issue_ready,
        input  full, count, issue_valid, issue_rob_idx, issue_a, issue_b, issue_opcode,
               issue_i
    );

    modport slave (
        input  in_valid, in_rob_idx, in_a_valid, in_b_valid, in_a_value, in_b_value,
               in_a_owner, in_b_owner, in_opcode, in_i, cdb_valid, cdb_tag, cdb_value,
               flush, issue_ready,
        output full, count, issue_valid, issue_rob_idx, issue_a, issue_b, issue_opcode,
               issue_i
    );
endinterface

// File: rtl/fxu_reservation_station.sv
// Age-ordered reservation station for one fixed-point unit.
// Compacting queue: slots 0..count-1 are live, slot 0 is the oldest. Missing
// operands are captured from the CDB; the oldest ready slot is issued through
// a valid/ready handshake and the slots above it shift down.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - synchronous active-low reset
//   rs    - slave side of fxu_reservation_station_if (dispatch, CDB, flush, issue)
module fxu_reservation_station #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input logic                     clk,
    input logic                     rst_n,
    fxu_reservation_station_if.slave rs
);
    typedef struct packed {
        logic [TAG_W-1:0]  rob;
        logic [3:0]        op;
        logic [7:0]        imm;
        logic              a_v;
        logic [DATA_W-1:0] a;
        logic [TAG_W-1:0]  a_own;
        logic              b_v;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  b_own;
    } slot_t;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    slot_t            woke   [DEPTH];
    slot_t            sel_slot;
    slot_t            in_slot;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] sel;
    logic [CNT_W-1:0] wr_idx;
    logic             any_ready;
    logic             issue_valid;
    logic             fire;
    logic             dispatch;
    logic             full;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign rs.full  = full;
    assign rs.count = count_q;

    // CDB wakeup applied to every slot; stale slots above count are never read.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = slot_q[i];
            if (rs.cdb_valid && !slot_q[i].a_v && slot_q[i].a_own == rs.cdb_tag) begin
                woke[i].a_v = 1'b1;
                woke[i].a   = rs.cdb_value;
            end
            if (rs.cdb_valid && !slot_q[i].b_v && slot_q[i].b_own == rs.cdb_tag) begin
                woke[i].b_v = 1'b1;
                woke[i].b   = rs.cdb_value;
            end
        end
    end

    // Select uses registered readiness only, so a broadcast never issues the same cycle.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        sel_slot  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count_q && slot_q[i].a_v && slot_q[i].b_v) begin
                any_ready = 1'b1;
                sel       = CNT_W'(i);
                sel_slot  = slot_q[i];
            end
        end
    end

    assign issue_valid      = any_ready && !rs.flush;
    assign fire             = issue_valid && rs.issue_ready;
    assign dispatch         = rs.in_valid && !full && !rs.flush;
    assign wr_idx           = count_q - CNT_W'(fire);

    assign rs.issue_valid   = issue_valid;
    assign rs.issue_rob_idx = issue_valid ? sel_slot.rob : '0;
    assign rs.issue_a       = issue_valid ? sel_slot.a   : '0;
    assign rs.issue_b       = issue_valid ? sel_slot.b   : '0;
    assign rs.issue_opcode  = issue_valid ? sel_slot.op  : '0;
    assign rs.issue_i       = issue_valid ? sel_slot.imm : '0;

    // Incoming entry, with a same-cycle CDB match bypassed straight in.
    always_comb begin
        in_slot       = '0;
        in_slot.rob   = rs.in_rob_idx;
        in_slot.op    = rs.in_opcode;
        in_slot.imm   = rs.in_i;
        in_slot.a_v   = rs.in_a_valid;
        in_slot.a     = rs.in_a_value;
        in_slot.a_own = rs.in_a_owner;
        in_slot.b_v   = rs.in_b_valid;
        in_slot.b     = rs.in_b_value;
        in_slot.b_own = rs.in_b_owner;
        if (rs.cdb_valid && !rs.in_a_valid && rs.in_a_owner == rs.cdb_tag) begin
            in_slot.a_v = 1'b1;
            in_slot.a   = rs.cdb_value;
        end
        if (rs.cdb_valid && !rs.in_b_valid && rs.in_b_owner == rs.cdb_tag) begin
            in_slot.b_v = 1'b1;
            in_slot.b   = rs.cdb_value;
        end
    end

    // Compaction: on issue, slots at or above sel take their upper neighbour.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            slot_d[i] = (fire && CNT_W'(i) >= sel) ? woke[i + 1] : woke[i];
        end
        slot_d[DEPTH-1] = woke[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (dispatch && CNT_W'(i) == wr_idx) begin
                slot_d[i] = in_slot;
            end
        end
        if (rs.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(dispatch) - CNT_W'(fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end
endmodule
